// File: rtl/cpu_pkg.sv
// Shared write-back definitions: write-select bit positions, default widths,
// and the pending-load queue entry.
package cpu_pkg;

    localparam int WSEL_PC = 2;
    localparam int WSEL_WE = 1;
    localparam int WSEL_FP = 0;

    localparam int XLEN_DEF = 32;
    localparam int RAW_DEF  = 5;

    typedef struct packed {
        logic               we;
        logic               fp;
        logic [RAW_DEF-1:0] rd;
    } wb_entry_t;

endpackage

// File: rtl/pend_fifo.sv
// In-order queue of outstanding load destinations; every slot is exposed
// so the write-back stage can build its busy scoreboard.
module pend_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_entry,
    input  logic                     i_pop,
    output wb_entry_t                o_head,
    output wb_entry_t                o_entries [DEPTH],
    output logic [DEPTH-1:0]         o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [AW-1:0]   w_off;

    // Contents need no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        w_off   = '0;
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = AW'(i) - r_rptr;
            o_valid[i] = {1'b0, w_off} < r_count;
        end
    end

    assign o_head    = r_mem[r_rptr];
    assign o_entries = r_mem;
    assign o_count   = r_count;

endmodule

// File: rtl/wb_stage_q.sv
// Registered write-back stage with an in-order pending-load queue and a
// per-register busy scoreboard for the int and fp register files.
module wb_stage_q
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RAW   = RAW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_wsel,
    input  logic                   in_frommem,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_data,
    input  logic [RAW-1:0]         in_rd,
    input  logic                   mem_rvalid,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   pcenable,
    output logic [XLEN-1:0]        next_pc,
    output logic                   wenable,
    output logic                   fmode,
    output logic [RAW-1:0]         wreg,
    output logic [XLEN-1:0]        wdata,
    output logic [(2**RAW)-1:0]    busy_int,
    output logic [(2**RAW)-1:0]    busy_fp,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   err_orphan
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t          w_head;
    wb_entry_t          w_entries [DEPTH];
    wb_entry_t          w_push_e;
    logic [DEPTH-1:0]   w_valid;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_coll;
    logic               w_qblk;
    logic               w_acc;
    logic               w_push;
    logic               w_x0;

    assign w_empty = pending == '0;
    assign w_full  = pending == CW'(DEPTH);
    assign w_pop   = mem_rvalid & ~w_empty;
    assign w_x0    = ~in_wsel[WSEL_FP] & (in_rd == '0);

    // The memory response owns the write port; a direct write must wait.
    assign w_coll  = w_pop & in_valid & in_wsel[WSEL_WE] & ~in_frommem;
    assign w_qblk  = in_frommem & w_full & ~mem_rvalid;

    assign in_ready = ~(w_coll | w_qblk);
    assign w_acc    = in_valid & in_ready;
    assign w_push   = w_acc & in_frommem;

    // x0 writes are dropped at push so they never mark busy or write back.
    assign w_push_e = '{
        we: in_wsel[WSEL_WE] & ~w_x0,
        fp: in_wsel[WSEL_FP],
        rd: RAW_DEF'(in_rd)
    };

    pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_entry   (w_push_e),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_count   (pending)
    );

    always_comb begin
        busy_int = '0;
        busy_fp  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && w_entries[i].we) begin
                if (w_entries[i].fp) begin
                    busy_fp[w_entries[i].rd] = 1'b1;
                end else begin
                    busy_int[w_entries[i].rd] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcenable   <= 1'b0;
            next_pc    <= '0;
            wenable    <= 1'b0;
            fmode      <= 1'b0;
            wreg       <= '0;
            wdata      <= '0;
            err_orphan <= 1'b0;
        end else begin
            pcenable <= w_acc & in_wsel[WSEL_PC];
            if (w_acc) begin
                next_pc <= in_pc;
            end
            if (w_pop) begin
                wenable <= w_head.we;
                fmode   <= w_head.fp;
                wreg    <= RAW'(w_head.rd);
                wdata   <= mem_rdata;
            end else if (w_acc && !in_frommem) begin
                wenable <= in_wsel[WSEL_WE] & ~w_x0;
                fmode   <= in_wsel[WSEL_FP];
                wreg    <= in_rd;
                wdata   <= in_data;
            end else begin
                wenable <= 1'b0;
            end
            err_orphan <= err_orphan | (mem_rvalid & w_empty);
        end
    end

endmodule

// File: doc/wb_stage_q.md
Name: wb_stage_q

Overview:
- Parametrised successor to the CPU's write-back stage: a registered, handshaked write-back unit with one register-file write port and two register files (int/fp).
- Adds an in-order pending-load queue, so load results return from memory with variable latency while ALU results and PC updates keep retiring.
- Provides a per-register busy scoreboard for hazard detection in decode.
- Sits between the exec/mem stage and the register files and PC register.

Parameters:
- XLEN, 32, data and PC width
- RAW, 5, register address width; NREG = 2**RAW
- DEPTH, 4, pending-load queue entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  write-back request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_wsel  in  3  [2]=pc enable, [1]=reg write enable, [0]=fp register file
- in_frommem  in  1  result comes from a later memory response
- in_pc  in  XLEN  next PC value
- in_data  in  XLEN  ALU result
- in_rd  in  RAW  destination register
- mem_rvalid  in  1  load data returning (in order, no backpressure)
- mem_rdata  in  XLEN  load data
- pcenable  out  1  registered PC write strobe
- next_pc  out  XLEN  registered PC value
- wenable  out  1  registered regfile write strobe
- fmode  out  1  registered file select (1=fp)
- wreg  out  RAW  registered write address
- wdata  out  XLEN  registered write data
- busy_int  out  NREG  int registers with a pending load
- busy_fp  out  NREG  fp registers with a pending load
- pending  out  log2(DEPTH)+1  queue occupancy
- err_orphan  out  1  sticky: mem_rvalid seen with empty queue

Behaviour:
- Reset (async): pcenable, wenable, fmode, err_orphan = 0; wreg, wdata, next_pc = 0; queue empty; pending = 0; busy_* = 0.
- All write-back outputs are registered, with 1-cycle latency from acceptance/response. Strobes are single-cycle pulses.
- Accept = in_valid & in_ready.
- Accept, frommem=0: next cycle, wenable=in_wsel[1], fmode=in_wsel[0], wreg=in_rd, wdata=in_data.
- Accept, frommem=1 with in_wsel[1]=1: push {rd, fp} into the queue; no regfile write now.
- Accept, frommem=1 with in_wsel[1]=0: acts as a load ack only. Push with an entry-valid-write bit of 0.
- Accept, any type: next cycle, pcenable=in_wsel[2], next_pc=in_pc, independent of the register path.
- mem_rvalid with queue non-empty: pop the head. Next cycle, wenable = head write bit, fmode = head fp, wreg = head rd, wdata = mem_rdata.
- mem_rvalid with queue empty: ignored; err_orphan set (cleared only by rst).
- Port collision: the memory response has priority on the write port.
  - in_ready = 0 when mem_rvalid & queue non-empty & in_valid & in_wsel[1] & !in_frommem.
  - Such a request is held by the producer.
- Full queue: in_ready = 0 when in_frommem & full & !(mem_rvalid). A simultaneous pop and push when full is allowed; occupancy is unchanged.
- Stall rule: a stalled request also stalls its PC update. An instruction retires atomically.
- x0: a write with fp=0 and rd=0 forces wenable=0, both on the direct path and at pop time. It is never marked busy.
- Scoreboard: combinational OR over valid queue entries with write bit=1.
  - busy_fp[r] = any entry with fp=1, rd=r; busy_int likewise.
  - Duplicate destinations stay busy until the last matching entry pops.
- pending: updates the same cycle as push/pop, visible next cycle.
- Queue pointers wrap modulo DEPTH. Occupancy is a separate counter, 0..DEPTH.

Decomposition:
- Shared package cpu_pkg:
  - WSEL_PC=2, WSEL_WE=1, WSEL_FP=0 bit indices
  - XLEN and RAW defaults
  - typedef wb_entry_t {we, fp, rd}
- One sub-module: pend_fifo (DEPTH-entry sync FIFO of wb_entry_t, exposing all entries for the scoreboard).

Test Plan:
- Reset mid-operation with 3 loads pending -> the same cycle: pending=0, busy_*=0, wenable=0; a later mem_rvalid sets err_orphan=1.
- ALU write wsel=3'b110, rd=5, data=0x1234, pc=0x40 -> next cycle: wenable=1, fmode=0, wreg=5, wdata=0x1234, pcenable=1, next_pc=0x40.
- Load to f3 (wsel=3'b011, frommem=1) -> busy_fp[3]=1, no write. mem_rvalid with data 0xDEADBEEF 4 cycles later -> next cycle: wenable=1, fmode=1, wreg=3, wdata=0xDEADBEEF, busy_fp[3]=0.
- Collision: ALU write held valid while mem_rvalid pops -> in_ready=0 that cycle; mem write appears first, ALU write the following cycle. No data loss.
- Fill DEPTH=4 loads -> in_ready=0 for a 5th load. A 5th load with a simultaneous mem_rvalid is accepted; pending stays 4.
- Two pending loads to x7, then a write to x0 -> busy_int[7] stays 1 until the second pop; the x0 write gives wenable=0 and busy_int[0]=0.
